// File: rtl/types_pkg.sv
// Shared types for the operation engine: opcode encoding and default word sizes.
package types_pkg;

  localparam int BITS_DEFAULT = 16;

  typedef enum logic [2:0] {
    RESET        = 3'd0,
    ADD          = 3'd1,
    SUB          = 3'd2,
    MUL          = 3'd3,
    COUNT_ONES   = 3'd4,
    LEADING_ONES = 3'd5
  } opr_mode_t;

  typedef logic [BITS_DEFAULT-1:0]           word_t;
  typedef logic [BITS_DEFAULT/2-1:0]         word_half_t;
  typedef logic [$clog2(BITS_DEFAULT):0]     word_log2_t;

endpackage

// File: rtl/op_engine_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, HALF iterations.
module op_engine_mul #(
  parameter int HALF = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HALF-1:0]   a,
  input  logic [HALF-1:0]   b,
  output logic              done,
  output logic [2*HALF-1:0] product
);

  localparam int W  = 2 * HALF;
  localparam int CW = $clog2(HALF) + 1;

  logic [W-1:0]    a_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    acc_d;
  logic [HALF-1:0] b_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;

  // The last iteration's sum is presented directly so the caller can capture it on the same edge.
  assign acc_d   = b_q[0] ? (acc_q + a_q) : acc_q;
  assign done    = busy_q && (cnt_q == CW'(HALF - 1));
  assign product = acc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= {{HALF{1'b0}}, a};
      b_q    <= b;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/op_engine.sv
// Handshaked operation engine (add/sub/mul/bit-count) with registered result held until taken.
// Bit-count opcodes are built only when OP_ENGINE_BITOPS_EN is defined.
module op_engine
  import types_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  opr_mode_t       mode,
  input  logic [BITS-1:0] operand,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] result,
  output logic            err
);

  localparam int HALF = BITS / 2;

  typedef enum logic [1:0] {IDLE, MUL_RUN, HOLD} state_t;

  state_t          state_q;
  logic            out_valid_q;
  logic            err_q;
  logic [BITS-1:0] result_q;

  logic [HALF-1:0] op_a;
  logic [HALF-1:0] op_b;
  logic            accept;
  logic            mul_start;
  logic            mul_done;
  logic [BITS-1:0] mul_product;
  logic [BITS-1:0] op_result_d;
  logic            op_err_d;

  assign op_a = operand[BITS-1:HALF];
  assign op_b = operand[HALF-1:0];

  // HOLD frees the slot in the same cycle the consumer takes the result.
  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (mode == MUL);

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

`ifdef OP_ENGINE_BITOPS_EN
  logic [BITS-1:0] ones_cnt;
  logic [BITS-1:0] lead_cnt;
  logic            lead_run;

  always_comb begin
    ones_cnt = '0;
    lead_cnt = '0;
    lead_run = 1'b1;
    for (int i = BITS - 1; i >= 0; i--) begin
      ones_cnt = ones_cnt + BITS'(operand[i]);
      if (lead_run && operand[i]) lead_cnt = lead_cnt + BITS'(1);
      else                        lead_run = 1'b0;
    end
  end
`endif

  always_comb begin
    op_result_d = '0;
    op_err_d    = 1'b0;
    case (mode)
      ADD:          op_result_d = {{HALF{1'b0}}, op_a} + {{HALF{1'b0}}, op_b};
      SUB:          op_result_d = {{HALF{1'b0}}, op_a} - {{HALF{1'b0}}, op_b};
      RESET, MUL:   ;
`ifdef OP_ENGINE_BITOPS_EN
      COUNT_ONES:   op_result_d = ones_cnt;
      LEADING_ONES: op_result_d = lead_cnt;
`endif
      default:      op_err_d = 1'b1;
    endcase
  end

  op_engine_mul #(.HALF(HALF)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        MUL_RUN: begin
          if (mul_done) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            result_q    <= mul_product;
            err_q       <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (mode == MUL) begin
              state_q     <= MUL_RUN;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              result_q    <= op_result_d;
              err_q       <= op_err_d;
            end
          end else if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_engine.sv
// Scoreboard bench for op_engine (BITS=16); bit-count cases follow OP_ENGINE_BITOPS_EN.
module tb_op_engine;
  import types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  opr_mode_t   mode;
  logic [15:0] operand;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [16:0] sb[$];

  op_engine #(.BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output monitor: every handshake pops one expected {err, result}.
  always @(negedge clk) begin
    logic [16:0] exp_v;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output result=%h err=%b required=no output", result, err);
      end else begin
        exp_v = sb.pop_front();
        if ({err, result} !== exp_v) begin
          errors++;
          $display("FAIL output result=%h err=%b required result=%h err=%b",
                   result, err, exp_v[15:0], exp_v[16]);
        end else begin
          $display("out  result=%h err=%b", result, err);
        end
      end
    end
  end

  function automatic logic [16:0] model(opr_mode_t m, logic [15:0] op);
    logic [15:0] a = {8'h00, op[15:8]};
    logic [15:0] b = {8'h00, op[7:0]};
    logic [15:0] lead = 16'd0;
    case (m)
      RESET: return 17'h0;
      ADD:   return {1'b0, a + b};
      SUB:   return {1'b0, a - b};
      MUL:   return {1'b0, a * b};
`ifdef OP_ENGINE_BITOPS_EN
      COUNT_ONES: return {1'b0, 16'($countones(op))};
      LEADING_ONES: begin
        for (int i = 15; i >= 0; i--) begin
          if (!op[i]) break;
          lead++;
        end
        return {1'b0, lead};
      end
`endif
      default: return {1'b1, 16'h0};
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input opr_mode_t m, input logic [15:0] op, input logic [16:0] exp_v);
    int n = 0;
    in_valid = 1'b1;
    mode     = m;
    operand  = op;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 50) break;
    end
    if (n > 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
    end else begin
      sb.push_back(exp_v);
      last_acc = cyc;
      $display("in   mode=%0d operand=%h", m, op);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, result, err, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state out_valid=%b result=%h err=%b in_ready=%b required 0/0000/0/1",
               out_valid, result, err, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_add_sub();
    send(ADD, 16'h0305, {1'b0, 16'h0008});
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_latency out_valid=%b required=1", out_valid);
    end
    @(posedge clk); #1;
    send(SUB, 16'h0305, {1'b0, 16'hFFFE});
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int k = 0;
    int ready_hi = 0;
    send(MUL, 16'hFFFF, {1'b0, 16'hFE01});
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0) ready_hi++;
    end
    checks++;
    if (k - 1 != 8) begin
      errors++;
      $display("FAIL mul_latency edges=%0d required=8", k - 1);
    end
    checks++;
    if (ready_hi != 0) begin
      errors++;
      $display("FAIL mul_in_ready cycles_high=%0d required=0", ready_hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bitops();
`ifdef OP_ENGINE_BITOPS_EN
    send(COUNT_ONES,   16'hF0F1, {1'b0, 16'h0009});
    send(LEADING_ONES, 16'hF0F1, {1'b0, 16'h0004});
    send(LEADING_ONES, 16'hFFFF, {1'b0, 16'h0010});
`else
    send(COUNT_ONES,   16'h00FF, {1'b1, 16'h0000});
    send(LEADING_ONES, 16'hFFFF, {1'b1, 16'h0000});
`endif
    send(opr_mode_t'(3'd7), 16'h1234, {1'b1, 16'h0000});
    send(opr_mode_t'(3'd6), 16'hFFFF, {1'b1, 16'h0000});
    send(RESET, 16'hABCD, {1'b0, 16'h0000});
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(ADD, 16'h0102, {1'b0, 16'h0003});
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({out_valid, result, err, in_ready} !== {1'b1, 16'h0003, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold out_valid=%b result=%h err=%b in_ready=%b required 1/0003/0/0",
                 out_valid, result, err, in_ready);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(ADD, 16'h0101, {1'b0, 16'h0002});
    @(negedge clk);
    checks++;
    if ({out_valid, result} !== {1'b1, 16'h0002}) begin
      errors++;
      $display("FAIL pass_through out_valid=%b result=%h required 1/0002", out_valid, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc[3];
    send(ADD, 16'h1111, {1'b0, 16'h0022}); acc[0] = last_acc;
    send(SUB, 16'h0102, {1'b0, 16'hFFFF}); acc[1] = last_acc;
    send(ADD, 16'hFF01, {1'b0, 16'h0100}); acc[2] = last_acc;
    checks++;
    if (acc[1] != acc[0] + 1 || acc[2] != acc[1] + 1) begin
      errors++;
      $display("FAIL back_to_back accept_cycles=%0d,%0d,%0d required consecutive",
               acc[0], acc[1], acc[2]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int stray = 0;
    send(MUL, 16'h0A0B, {1'b0, 16'h006E});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({out_valid, result, err, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset out_valid=%b result=%h err=%b in_ready=%b required 0/0000/0/1",
               out_valid, result, err, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL discarded_mul out_valid_cycles=%0d required=0", stray);
    end
    @(posedge clk); #1;
    send(ADD, 16'h0203, {1'b0, 16'h0005});
    @(negedge clk);
    checks++;
    if ({out_valid, result} !== {1'b1, 16'h0005}) begin
      errors++;
      $display("FAIL post_reset_add out_valid=%b result=%h required 1/0005", out_valid, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    opr_mode_t   m;
    logic [15:0] op;
    for (int i = 0; i < 24; i++) begin
      m  = opr_mode_t'($urandom_range(0, 7));
      op = 16'($urandom);
      send(m, op, model(m, op));
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    mode      = ADD;
    operand   = 16'h0;
    out_ready = 1'b1;
    test_reset();
    test_add_sub();
    test_mul();
    test_bitops();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/op_engine.md
# op_engine

Parametrised, handshaked operation engine that supersedes the fixed-width select-and-register datapath. It accepts one BITS-wide operand word plus an opcode per transaction, computes add/sub/multiply on the two operand halves or a bit-count on the full word, and holds the result until the consumer takes it. Multiply is iterative (shift-add), so the block carries a real FSM with valid/ready flow control on both sides. It sits between the switch/stimulus front end and the LED/result register stage.

## Interface
- BITS, 16, operand/result width; must be even and ≥ 4
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  engine can accept a transaction this cycle
- mode  input  opr_mode_t  opcode: RESET, ADD, SUB, MUL, COUNT_ONES, LEADING_ONES
- operand  input  BITS  A = operand[BITS-1:BITS/2], B = operand[BITS/2-1:0], both unsigned
- out_valid  output  1  result/err valid
- out_ready  input  1  consumer takes result this cycle
- result  output  BITS  operation result
- err  output  1  opcode unsupported in this build or undefined

## Operation
- Transaction accepted on a rising edge where in_valid && in_ready; mode/operand sampled only then.
- Arithmetic, all in BITS bits, operands zero-extended: ADD = A + B (never overflows); SUB = A − B, two's-complement wrap; MUL = A × B (exact, fits BITS).
- COUNT_ONES = number of 1s in full operand; LEADING_ONES = consecutive 1s from operand MSB (0..BITS); both zero-extended to BITS.
- RESET opcode: result 0, err 0, latency as single-cycle op.
- Undefined opcode: result 0, err 1.
- FSM states: IDLE, MUL_RUN, HOLD.
  - IDLE: in_ready=1. Accept non-MUL → compute combinationally, register, → HOLD. Accept MUL → load A, B, zero accumulator, counter=0, → MUL_RUN.
  - MUL_RUN: in_ready=0; each cycle if B[0] add A to accumulator, A<<=1, B>>=1, counter++; after BITS/2 iterations → HOLD with result = accumulator.
  - HOLD: out_valid=1, result/err stable. If out_ready: in_ready=1 same cycle (pass-through accept); with in_valid, next transaction accepted on that edge (→ HOLD or MUL_RUN); without, → IDLE.
- out_ready ignored when out_valid=0.

## Timing
- Reset (rst=0): state IDLE, out_valid=0, result=0, err=0, in_ready=1 combinationally from IDLE; accumulator and counter cleared. In-flight multiply discarded, no output produced.
- Single-cycle ops: out_valid rises on the edge that accepts the transaction (1-cycle latency). Back-to-back throughput one per cycle while out_ready=1.
- MUL: out_valid rises BITS/2 edges after the accepting edge; in_ready low for those BITS/2 cycles and in HOLD until out_ready.
- Backpressure: in HOLD with out_ready=0, result/err/out_valid held indefinitely; in_ready=0.
- in_ready is combinational from state and out_ready only; never from in_valid.

## Configuration
- OP_ENGINE_BITOPS_EN defined: COUNT_ONES and LEADING_ONES implemented as above.
- Undefined: bit-count logic not built; those opcodes complete with 1-cycle latency, result 0, err 1. Other opcodes unaffected.

## Structure
- Shared package types_pkg: opr_mode_t (extended with COUNT_ONES, LEADING_ONES), BITS default, word_t, word_half_t, word_log2_t.
- Sub-module op_engine_mul: shift-add iterative multiplier (start, A, B in; done, product out), instantiated once; FSM, bit-count logic and output register live in op_engine.

## Test plan
- BITS=16, ADD operand 0x0305 → result 0x0008, err 0, out_valid one cycle after accept; then SUB 0x0305 → 0xFFFE.
- MUL operand 0xFFFF → result 0xFE01 exactly 8 cycles after accept; in_ready low throughout MUL_RUN.
- COUNT_ONES 0xF0F1 → 0x0009; LEADING_ONES 0xF0F1 → 0x0004; LEADING_ONES 0xFFFF → 0x0010 (macro defined).
- out_ready held low 5 cycles after ADD 0x0102 → result 0x0003 stable, in_ready 0; out_ready=1 with in_valid ADD 0x0101 → new result 0x0002 next cycle, no gap.
- rst pulsed low 3 cycles into MUL 0x0A0B → immediately out_valid 0, result 0, err 0; no result emitted after release; next ADD completes normally.
- Macro undefined, COUNT_ONES 0x00FF → result 0, err 1; undefined opcode value → result 0, err 1.
